mem_arbiter: RTL and testbench

- Parametrised N-master arbiter for the shared memory port; successor to the two-master memory controller.
- Sits between the pipeline masters (inst fetch, mem access, future DMA/debug) and the memory slave (irom/RAM).
- Adds selectable fixed or round-robin priority, registered grant, and a slave ready handshake with wait states.
- Adds a per-access timeout with an error response, and per-master stall generation.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-master arbiter in front of the shared memory slave port.
// Fixed or round-robin priority, registered grant, slave wait states,
// per-access timeout with error response, combinational per-master stall.
//
// Ports:
//   CLK, RESET      clock, synchronous active-low reset
//   HTRANS/HADDR/HWRITE/HWDATA  per-master request (flattened buses)
//   HREADY/HERROR/HRDATA        completion pulse, abort flag, read data
//   stall                       HTRANS & ~HREADY
//   PADDR/PWRITE/PDATA/PVALID   registered slave request
//   PREADY/PRDATA               slave completion and read data
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 15
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_MASTERS-1:0]        HTRANS,
    input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR,
    input  logic [NUM_MASTERS-1:0]        HWRITE,
    input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA,
    output logic [NUM_MASTERS-1:0]        HREADY,
    output logic                          HERROR,
    output logic [DATA_W-1:0]             HRDATA,
    output logic [NUM_MASTERS-1:0]        stall,
    output logic [ADDR_W-1:0]             PADDR,
    output logic                          PWRITE,
    output logic [DATA_W-1:0]             PDATA,
    output logic                          PVALID,
    input  logic                          PREADY,
    input  logic [DATA_W-1:0]             PRDATA
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       owner, last, win, ptr;
    logic [7:0]             cnt;
    logic [NUM_MASTERS-1:0] req, owner_oh;
    logic                   win_vld, done, load;
    logic [ADDR_W-1:0]      win_addr;
    logic                   win_write;
    logic [DATA_W-1:0]      win_wdata;

    // During ACCESS the owner still holds HTRANS, so its bit is masked
    // and the scan continues from the owner (it becomes last this cycle).
    assign ptr = (state == ACCESS) ? owner : last;

    always_comb begin
        int base_i;
        int idx_i;
        req     = HTRANS;
        win     = '0;
        win_vld = 1'b0;
        base_i  = 0;
        idx_i   = 0;
        if (state == ACCESS) begin
            req[owner] = 1'b0;
        end
        if (RR_MODE != 0) begin
            base_i = int'(ptr) + 1;
            if (base_i >= NUM_MASTERS) begin
                base_i = 0;
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx_i = base_i + k;
            if (idx_i >= NUM_MASTERS) begin
                idx_i = idx_i - NUM_MASTERS;
            end
            if (!win_vld && req[IDX_W'(idx_i)]) begin
                win_vld = 1'b1;
                win     = IDX_W'(idx_i);
            end
        end
    end

    assign win_addr  = HADDR[int'(win)*ADDR_W +: ADDR_W];
    assign win_write = HWRITE[win];
    assign win_wdata = HWDATA[int'(win)*DATA_W +: DATA_W];

    assign done = (state == ACCESS) && (PREADY || (cnt == CNT_LAST));
    assign load = win_vld && ((state == IDLE) || done);

    assign owner_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner;
    assign stall    = HTRANS & ~HREADY;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_vld) state_nxt = ACCESS;
            ACCESS:  if (done && !win_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            PVALID <= 1'b0;
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PDATA  <= '0;
            HREADY <= '0;
            HERROR <= 1'b0;
            HRDATA <= '0;
            owner  <= '0;
            cnt    <= '0;
            last   <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            HREADY <= '0;
            HERROR <= 1'b0;
            if ((state == ACCESS) && !done) begin
                cnt <= cnt + 8'd1;
            end
            if (done) begin
                HREADY <= owner_oh;
                HERROR <= ~PREADY;
                last   <= owner;
                if (PREADY && !PWRITE) begin
                    HRDATA <= PRDATA;
                end
                if (!win_vld) begin
                    PVALID <= 1'b0;
                end
            end
            // New grant: from IDLE, or back-to-back with no bubble.
            if (load) begin
                PADDR  <= win_addr;
                PWRITE <= win_write;
                PDATA  <= win_wdata;
                owner  <= win;
                PVALID <= 1'b1;
                cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// u_fix: 3 masters fixed priority; u_rr: 4 masters round-robin, TIMEOUT=4.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    logic [2:0]      f_htrans, f_hwrite, f_hready, f_stall;
    logic [3*AW-1:0] f_haddr;
    logic [3*DW-1:0] f_hwdata;
    logic            f_herror, f_pwrite, f_pvalid, f_pready;
    logic [DW-1:0]   f_hrdata, f_pdata, f_prdata;
    logic [AW-1:0]   f_paddr;

    logic [3:0]      r_htrans, r_hwrite, r_hready, r_stall;
    logic [4*AW-1:0] r_haddr;
    logic [4*DW-1:0] r_hwdata;
    logic            r_herror, r_pwrite, r_pvalid, r_pready;
    logic [DW-1:0]   r_hrdata, r_pdata, r_prdata;
    logic [AW-1:0]   r_paddr;

    mem_arbiter #(
        .NUM_MASTERS(3), .ADDR_W(AW), .DATA_W(DW),
        .RR_MODE(0), .TIMEOUT(15)
    ) u_fix (
        .CLK(CLK), .RESET(RESET),
        .HTRANS(f_htrans), .HADDR(f_haddr),
        .HWRITE(f_hwrite), .HWDATA(f_hwdata),
        .HREADY(f_hready), .HERROR(f_herror),
        .HRDATA(f_hrdata), .stall(f_stall),
        .PADDR(f_paddr), .PWRITE(f_pwrite),
        .PDATA(f_pdata), .PVALID(f_pvalid),
        .PREADY(f_pready), .PRDATA(f_prdata)
    );

    mem_arbiter #(
        .NUM_MASTERS(4), .ADDR_W(AW), .DATA_W(DW),
        .RR_MODE(1), .TIMEOUT(4)
    ) u_rr (
        .CLK(CLK), .RESET(RESET),
        .HTRANS(r_htrans), .HADDR(r_haddr),
        .HWRITE(r_hwrite), .HWDATA(r_hwdata),
        .HREADY(r_hready), .HERROR(r_herror),
        .HRDATA(r_hrdata), .stall(r_stall),
        .PADDR(r_paddr), .PWRITE(r_pwrite),
        .PDATA(r_pdata), .PVALID(r_pvalid),
        .PREADY(r_pready), .PRDATA(r_prdata)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        tick();
        tick();
        checks++; if (f_pvalid !== 1'b0) begin errors++; $display("FAIL rst_f_pvalid: got %h want 0", f_pvalid); end
        checks++; if (f_hready !== 3'b000) begin errors++; $display("FAIL rst_f_hready: got %b want 000", f_hready); end
        checks++; if (f_herror !== 1'b0) begin errors++; $display("FAIL rst_f_herror: got %h want 0", f_herror); end
        checks++; if (f_pwrite !== 1'b0) begin errors++; $display("FAIL rst_f_pwrite: got %h want 0", f_pwrite); end
        checks++; if (f_paddr !== 64'h0) begin errors++; $display("FAIL rst_f_paddr: got %h want 0", f_paddr); end
        checks++; if (f_pdata !== 64'h0) begin errors++; $display("FAIL rst_f_pdata: got %h want 0", f_pdata); end
        checks++; if (f_hrdata !== 64'h0) begin errors++; $display("FAIL rst_f_hrdata: got %h want 0", f_hrdata); end
        checks++; if (f_stall !== 3'b000) begin errors++; $display("FAIL rst_f_stall: got %b want 000", f_stall); end
        checks++; if (r_pvalid !== 1'b0) begin errors++; $display("FAIL rst_r_pvalid: got %h want 0", r_pvalid); end
        checks++; if (r_hready !== 4'b0000) begin errors++; $display("FAIL rst_r_hready: got %b want 0000", r_hready); end
        RESET = 1'b1;
    endtask

    task automatic test_single_read();
        f_haddr[0 +: AW] = 64'h1000;
        f_htrans = 3'b001;
        f_pready = 1'b1;
        f_prdata = 64'hDEAD;
        #1;
        checks++; if (f_stall !== 3'b001) begin errors++; $display("FAIL rd_stall_n: got %b want 001", f_stall); end
        tick();
        checks++; if (f_pvalid !== 1'b1) begin errors++; $display("FAIL rd_pvalid: got %h want 1", f_pvalid); end
        checks++; if (f_paddr !== 64'h1000) begin errors++; $display("FAIL rd_paddr: got %h want 1000", f_paddr); end
        checks++; if (f_pwrite !== 1'b0) begin errors++; $display("FAIL rd_pwrite: got %h want 0", f_pwrite); end
        checks++; if (f_hready !== 3'b000) begin errors++; $display("FAIL rd_hready_n1: got %b want 000", f_hready); end
        checks++; if (f_stall !== 3'b001) begin errors++; $display("FAIL rd_stall_n1: got %b want 001", f_stall); end
        tick();
        checks++; if (f_hready !== 3'b001) begin errors++; $display("FAIL rd_hready_n2: got %b want 001", f_hready); end
        checks++; if (f_herror !== 1'b0) begin errors++; $display("FAIL rd_herror: got %h want 0", f_herror); end
        checks++; if (f_hrdata !== 64'hDEAD) begin errors++; $display("FAIL rd_hrdata: got %h want dead", f_hrdata); end
        checks++; if (f_pvalid !== 1'b0) begin errors++; $display("FAIL rd_pvalid_end: got %h want 0", f_pvalid); end
        checks++; if (f_stall !== 3'b000) begin errors++; $display("FAIL rd_stall_n2: got %b want 000", f_stall); end
        f_htrans = 3'b000;
        tick();
        checks++; if (f_hready !== 3'b000) begin errors++; $display("FAIL rd_hready_n3: got %b want 000", f_hready); end
    endtask

    // All three request; owner masking alternates 0 and 1, master 2 starves.
    task automatic test_fixed_priority();
        logic [2:0]    exp_rdy [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
        logic [AW-1:0] exp_adr [4] = '{64'h200, 64'h100, 64'h200, 64'h100};
        logic [2:0]    es;
        f_haddr[0*AW +: AW] = 64'h100;
        f_haddr[1*AW +: AW] = 64'h200;
        f_haddr[2*AW +: AW] = 64'h300;
        f_prdata = 64'h11;
        f_pready = 1'b1;
        f_htrans = 3'b111;
        tick();
        checks++; if (f_paddr !== 64'h100) begin errors++; $display("FAIL fx_first_paddr: got %h want 100", f_paddr); end
        for (int k = 0; k < 4; k++) begin
            tick();
            es = ~exp_rdy[k];
            checks++; if (f_hready !== exp_rdy[k]) begin errors++; $display("FAIL fx_hready[%0d]: got %b want %b", k, f_hready, exp_rdy[k]); end
            checks++; if (f_paddr !== exp_adr[k]) begin errors++; $display("FAIL fx_paddr[%0d]: got %h want %h", k, f_paddr, exp_adr[k]); end
            checks++; if (f_pvalid !== 1'b1) begin errors++; $display("FAIL fx_pvalid[%0d]: got %h want 1", k, f_pvalid); end
            checks++; if (f_stall !== es) begin errors++; $display("FAIL fx_stall[%0d]: got %b want %b", k, f_stall, es); end
        end
        f_htrans = 3'b000;
        tick();
        checks++; if (f_hready !== 3'b001) begin errors++; $display("FAIL fx_drop_hready: got %b want 001", f_hready); end
        checks++; if (f_pvalid !== 1'b0) begin errors++; $display("FAIL fx_drop_pvalid: got %h want 0", f_pvalid); end
        checks++; if (f_hrdata !== 64'h11) begin errors++; $display("FAIL fx_hrdata: got %h want 11", f_hrdata); end
        tick();
    endtask

    task automatic test_wait_write();
        f_hwdata[1*DW +: DW] = 64'h55;
        f_hwrite = 3'b010;
        f_htrans = 3'b010;
        f_pready = 1'b0;
        f_prdata = 64'hBAD;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (f_pvalid !== 1'b1) begin errors++; $display("FAIL ws_pvalid[%0d]: got %h want 1", k, f_pvalid); end
            checks++; if (f_pdata !== 64'h55) begin errors++; $display("FAIL ws_pdata[%0d]: got %h want 55", k, f_pdata); end
            checks++; if (f_pwrite !== 1'b1) begin errors++; $display("FAIL ws_pwrite[%0d]: got %h want 1", k, f_pwrite); end
            checks++; if (f_paddr !== 64'h200) begin errors++; $display("FAIL ws_paddr[%0d]: got %h want 200", k, f_paddr); end
            checks++; if (f_hready !== 3'b000) begin errors++; $display("FAIL ws_hready[%0d]: got %b want 000", k, f_hready); end
        end
        f_pready = 1'b1;
        tick();
        checks++; if (f_hready !== 3'b010) begin errors++; $display("FAIL ws_done_hready: got %b want 010", f_hready); end
        checks++; if (f_herror !== 1'b0) begin errors++; $display("FAIL ws_herror: got %h want 0", f_herror); end
        checks++; if (f_hrdata !== 64'h11) begin errors++; $display("FAIL ws_hrdata: got %h want 11", f_hrdata); end
        checks++; if (f_pvalid !== 1'b0) begin errors++; $display("FAIL ws_pvalid_end: got %h want 0", f_pvalid); end
        f_htrans = 3'b000;
        f_hwrite = 3'b000;
        f_pready = 1'b0;
        tick();
        checks++; if (f_hready !== 3'b000) begin errors++; $display("FAIL ws_hready_after: got %b want 000", f_hready); end
    endtask

    task automatic test_round_robin();
        logic [3:0]    exp_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [AW-1:0] exp_adr [4] = '{64'h20, 64'h30, 64'h40, 64'h10};
        for (int i = 0; i < 4; i++) begin
            r_haddr[i*AW +: AW] = AW'((i + 1) * 16);
        end
        r_prdata = 64'h77;
        r_pready = 1'b1;
        r_htrans = 4'b1111;
        tick();
        checks++; if (r_paddr !== 64'h10) begin errors++; $display("FAIL rr_first_paddr: got %h want 10", r_paddr); end
        checks++; if (r_hready !== 4'b0000) begin errors++; $display("FAIL rr_first_hready: got %b want 0000", r_hready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (r_hready !== exp_rdy[k]) begin errors++; $display("FAIL rr_hready[%0d]: got %b want %b", k, r_hready, exp_rdy[k]); end
            checks++; if (r_paddr !== exp_adr[k]) begin errors++; $display("FAIL rr_paddr[%0d]: got %h want %h", k, r_paddr, exp_adr[k]); end
            checks++; if (r_pvalid !== 1'b1) begin errors++; $display("FAIL rr_pvalid[%0d]: got %h want 1", k, r_pvalid); end
            checks++; if (r_hrdata !== 64'h77) begin errors++; $display("FAIL rr_hrdata[%0d]: got %h want 77", k, r_hrdata); end
        end
        r_htrans = 4'b0000;
        tick();
        checks++; if (r_hready !== 4'b0001) begin errors++; $display("FAIL rr_last_hready: got %b want 0001", r_hready); end
        checks++; if (r_pvalid !== 1'b0) begin errors++; $display("FAIL rr_end_pvalid: got %h want 0", r_pvalid); end
        tick();
    endtask

    // last = 0 here, so masters 2 and 3 requesting -> 2 first, 3 after abort.
    task automatic test_timeout();
        r_prdata = 64'hEE;
        r_pready = 1'b0;
        r_htrans = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (r_pvalid !== 1'b1) begin errors++; $display("FAIL to_pvalid[%0d]: got %h want 1", k, r_pvalid); end
            checks++; if (r_paddr !== 64'h30) begin errors++; $display("FAIL to_paddr[%0d]: got %h want 30", k, r_paddr); end
            checks++; if (r_hready !== 4'b0000) begin errors++; $display("FAIL to_hready[%0d]: got %b want 0000", k, r_hready); end
            checks++; if (r_herror !== 1'b0) begin errors++; $display("FAIL to_herror[%0d]: got %h want 0", k, r_herror); end
        end
        tick();
        checks++; if (r_hready !== 4'b0100) begin errors++; $display("FAIL to_abort_hready: got %b want 0100", r_hready); end
        checks++; if (r_herror !== 1'b1) begin errors++; $display("FAIL to_abort_herror: got %h want 1", r_herror); end
        checks++; if (r_hrdata !== 64'h77) begin errors++; $display("FAIL to_abort_hrdata: got %h want 77", r_hrdata); end
        checks++; if (r_pvalid !== 1'b1) begin errors++; $display("FAIL to_next_pvalid: got %h want 1", r_pvalid); end
        checks++; if (r_paddr !== 64'h40) begin errors++; $display("FAIL to_next_paddr: got %h want 40", r_paddr); end
        r_htrans = 4'b1000;
        r_pready = 1'b1;
        tick();
        checks++; if (r_hready !== 4'b1000) begin errors++; $display("FAIL to_ok_hready: got %b want 1000", r_hready); end
        checks++; if (r_herror !== 1'b0) begin errors++; $display("FAIL to_ok_herror: got %h want 0", r_herror); end
        checks++; if (r_hrdata !== 64'hEE) begin errors++; $display("FAIL to_ok_hrdata: got %h want ee", r_hrdata); end
        checks++; if (r_pvalid !== 1'b0) begin errors++; $display("FAIL to_ok_pvalid: got %h want 0", r_pvalid); end
        r_htrans = 4'b0000;
        r_pready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        r_htrans = 4'b0001;
        r_pready = 1'b1;
        tick();
        tick();
        checks++; if (r_hready !== 4'b0001) begin errors++; $display("FAIL rm_pre_hready: got %b want 0001", r_hready); end
        r_htrans = 4'b0100;
        r_pready = 1'b0;
        tick();
        checks++; if (r_paddr !== 64'h30) begin errors++; $display("FAIL rm_grant_paddr: got %h want 30", r_paddr); end
        RESET = 1'b0;
        tick();
        checks++; if (r_pvalid !== 1'b0) begin errors++; $display("FAIL rm_pvalid: got %h want 0", r_pvalid); end
        checks++; if (r_hready !== 4'b0000) begin errors++; $display("FAIL rm_hready: got %b want 0000", r_hready); end
        checks++; if (r_paddr !== 64'h0) begin errors++; $display("FAIL rm_paddr: got %h want 0", r_paddr); end
        RESET = 1'b1;
        r_htrans = 4'b0011;
        r_pready = 1'b1;
        tick();
        checks++; if (r_paddr !== 64'h10) begin errors++; $display("FAIL rm_restart_paddr: got %h want 10", r_paddr); end
        checks++; if (r_pvalid !== 1'b1) begin errors++; $display("FAIL rm_restart_pvalid: got %h want 1", r_pvalid); end
        checks++; if (r_hready !== 4'b0000) begin errors++; $display("FAIL rm_no_hready: got %b want 0000", r_hready); end
        tick();
        checks++; if (r_hready !== 4'b0001) begin errors++; $display("FAIL rm_restart_hready: got %b want 0001", r_hready); end
        r_htrans = 4'b0000;
        tick();
    endtask

    initial begin
        RESET    = 1'b0;
        f_htrans = '0; f_hwrite = '0; f_haddr = '0; f_hwdata = '0;
        f_pready = 1'b0; f_prdata = '0;
        r_htrans = '0; r_hwrite = '0; r_haddr = '0; r_hwdata = '0;
        r_pready = 1'b0; r_prdata = '0;
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_wait_write();
        test_round_robin();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
